// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the MISC-V hazard controller and the Forward unit.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    // Forward unit operand-source select; kept here so both blocks agree.
    localparam logic [1:0] FWD_MEM = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_RF  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch redirects, memory-wait
// freezes, a wait watchdog and saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W              = 3,
    parameter int unsigned ZERO_REG_HARDWIRED = 0,
    parameter int unsigned MEM_TIMEOUT        = 64,
    parameter int unsigned CNT_W              = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_writes_rd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             ctr_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic freeze;
    logic redirect;
    logic src_hit;
    logic zero_dest;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign freeze    = ((state_q == ST_MEM_WAIT) | mem_req) & ~mem_ready;
    assign redirect  = ex_branch_taken & ~freeze;
    assign src_hit   = (id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd));
    assign zero_dest = (ZERO_REG_HARDWIRED != 0) && (ex_rd == '0);
    assign load_use  = ex_valid & ex_is_load & ex_writes_rd & id_valid & src_hit & ~zero_dest;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (reset) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state_q == ST_FAULT) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (freeze) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            stall_inc = 1'b1;
        end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
        end
    end

    // wait_d holds the post-increment count, so a limit of N faults after N frozen cycles.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    if (MEM_TIMEOUT == 1) begin
                        state_d = ST_FAULT;
                        wait_d  = '0;
                    end else begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if ((MEM_TIMEOUT != 0) && (wait_d == WAIT_LIMIT)) begin
                        state_d = ST_FAULT;
                        wait_d  = '0;
                    end
                end
            end
            ST_FAULT: begin
                wait_d = '0;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign fault = (state_q == ST_FAULT);
    assign state = state_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (ctr_clr),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (ctr_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances share stimulus and differ in
// zero-register handling, watchdog limit and counter width.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, id_uses_rs1, id_uses_rs2;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_is_load, ex_writes_rd, ex_branch_taken;
    logic       mem_req, mem_ready, ctr_clr;

    logic [1:0]  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, fault;
    logic [1:0]  state0, state1;
    logic [3:0]  stall0, flush0;
    logic [15:0] stall1, flush1;

    // dut0: register 0 stalls, watchdog 4, 4-bit counters
    hazard_ctrl #(.REG_W(3), .ZERO_REG_HARDWIRED(0), .MEM_TIMEOUT(4), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_writes_rd(ex_writes_rd), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .ctr_clr(ctr_clr), .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]),
        .exmem_en(exmem_en[0]), .memwb_en(memwb_en[0]), .ifid_flush(ifid_flush[0]),
        .idex_flush(idex_flush[0]), .fault(fault[0]), .state(state0),
        .stall_cnt(stall0), .flush_cnt(flush0)
    );

    // dut1: register 0 hardwired, watchdog disabled, 16-bit counters
    hazard_ctrl #(.REG_W(3), .ZERO_REG_HARDWIRED(1), .MEM_TIMEOUT(0), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_writes_rd(ex_writes_rd), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .ctr_clr(ctr_clr), .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]),
        .exmem_en(exmem_en[1]), .memwb_en(memwb_en[1]), .ifid_flush(ifid_flush[1]),
        .idex_flush(idex_flush[1]), .fault(fault[1]), .state(state1),
        .stall_cnt(stall1), .flush_cnt(flush1)
    );

    // control word: {pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush}
    localparam logic [6:0] NORM = 7'b11111_00;
    localparam logic [6:0] LU   = 7'b00111_01;
    localparam logic [6:0] RED  = 7'b11111_11;
    localparam logic [6:0] FRZ  = 7'b00000_00;
    localparam logic [6:0] RST  = 7'b00000_11;

    typedef struct {
        string      tag;
        int         dut;
        logic [9:0] ctl;
        int         stall;
        int         flush;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    function automatic logic [9:0] c(logic [6:0] b, logic f, logic [1:0] s);
        return {b, f, s};
    endfunction

    task automatic push2(string tag, logic [9:0] c0, logic [9:0] c1,
                         int s0, int f0, int s1, int f1);
        exp_t e;
        e.tag = tag; e.dut = 0; e.ctl = c0; e.stall = s0; e.flush = f0;
        sb.push_back(e);
        e.dut = 1; e.ctl = c1; e.stall = s1; e.flush = f1;
        sb.push_back(e);
    endtask

    task automatic idle();
        reset = 0; id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_valid = 0; ex_is_load = 0;
        ex_writes_rd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0; ctr_clr = 0;
    endtask

    task automatic set_lu(logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2, logic u1, logic u2);
        ex_valid = 1; ex_is_load = 1; ex_writes_rd = 1; ex_rd = rd;
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();

        idle(); reset = 1;
        push2("reset", c(RST,0,0), c(RST,0,0), 0, 0, 0, 0); tick();
        idle();
        push2("normal", c(NORM,0,0), c(NORM,0,0), 0, 0, 0, 0); tick();

        idle(); set_lu(3, 5, 3, 0, 1);
        push2("lu_rs2", c(LU,0,0), c(LU,0,0), 0, 0, 0, 0); tick();
        idle();
        push2("lu_after", c(NORM,0,0), c(NORM,0,0), 1, 0, 1, 0); tick();
        idle(); set_lu(0, 5, 0, 0, 1);
        push2("lu_zero", c(LU,0,0), c(NORM,0,0), 1, 0, 1, 0); tick();
        idle();
        push2("lu_zero_after", c(NORM,0,0), c(NORM,0,0), 2, 0, 1, 0); tick();

        idle(); set_lu(3, 5, 3, 0, 1); ex_branch_taken = 1;
        push2("branch_prio", c(RED,0,0), c(RED,0,0), 2, 0, 1, 0); tick();
        idle();
        push2("branch_after", c(NORM,0,0), c(NORM,0,0), 2, 1, 1, 1); tick();
        idle(); ctr_clr = 1;
        push2("clr", c(NORM,0,0), c(NORM,0,0), 2, 1, 1, 1); tick();

        for (int k = 1; k <= 3; k++) begin
            idle(); mem_req = 1;
            push2("mem_wait", c(FRZ,0,(k == 1) ? 2'd0 : 2'd1), c(FRZ,0,(k == 1) ? 2'd0 : 2'd1),
                  k - 1, 0, k - 1, 0);
            tick();
        end
        idle(); mem_req = 1; mem_ready = 1;
        push2("mem_ready", c(NORM,0,1), c(NORM,0,1), 3, 0, 3, 0); tick();
        idle();
        push2("mem_done", c(NORM,0,0), c(NORM,0,0), 3, 0, 3, 0); tick();
        idle(); mem_req = 1; mem_ready = 1;
        push2("mem_hit", c(NORM,0,0), c(NORM,0,0), 3, 0, 3, 0); tick();
        idle();
        push2("mem_hit_after", c(NORM,0,0), c(NORM,0,0), 3, 0, 3, 0); tick();

        idle(); mem_req = 1; ex_branch_taken = 1;
        push2("frz_branch", c(FRZ,0,0), c(FRZ,0,0), 3, 0, 3, 0); tick();
        idle(); mem_req = 1; mem_ready = 1; ex_branch_taken = 1;
        push2("ready_branch", c(RED,0,1), c(RED,0,1), 4, 0, 4, 0); tick();
        idle();
        push2("ready_branch_after", c(NORM,0,0), c(NORM,0,0), 4, 1, 4, 1); tick();
        idle(); ctr_clr = 1;
        push2("clr2", c(NORM,0,0), c(NORM,0,0), -1, -1, -1, -1); tick();

        for (int k = 1; k <= 8; k++) begin
            logic [9:0] e0, e1;
            e0 = (k == 1) ? c(FRZ,0,0) : (k <= 4) ? c(FRZ,0,1) : c(FRZ,1,2);
            e1 = (k == 1) ? c(FRZ,0,0) : c(FRZ,0,1);
            idle(); mem_req = 1;
            push2("watchdog", e0, e1, (k - 1 < 4) ? k - 1 : 4, 0, k - 1, 0);
            tick();
        end
        idle(); reset = 1; mem_req = 1;
        push2("reset_fault", c(RST,1,2), c(RST,0,1), 4, 0, 8, 0); tick();
        idle();
        push2("after_reset", c(NORM,0,0), c(NORM,0,0), 0, 0, 0, 0); tick();

        for (int i = 0; i < 20; i++) begin
            idle(); set_lu(3, 3, 6, 1, 0);
            push2("sat", c(LU,0,0), c(LU,0,0), (i < 15) ? i : 15, 0, i, 0);
            tick();
        end
        idle(); set_lu(3, 3, 6, 1, 0); ctr_clr = 1;
        push2("clr_vs_inc", c(LU,0,0), c(LU,0,0), 15, 0, 20, 0); tick();
        idle();
        push2("clr_after", c(NORM,0,0), c(NORM,0,0), 0, 0, 0, 0); tick();

        idle(); set_lu(4, 4, 4, 1, 1); ex_valid = 0;
        push2("q_ex_valid", c(NORM,0,0), c(NORM,0,0), -1, -1, -1, -1); tick();
        idle(); set_lu(4, 4, 4, 1, 1); ex_is_load = 0;
        push2("q_is_load", c(NORM,0,0), c(NORM,0,0), -1, -1, -1, -1); tick();
        idle(); set_lu(4, 4, 4, 1, 1); ex_writes_rd = 0;
        push2("q_writes_rd", c(NORM,0,0), c(NORM,0,0), -1, -1, -1, -1); tick();
        idle(); set_lu(4, 4, 4, 1, 1); id_valid = 0;
        push2("q_id_valid", c(NORM,0,0), c(NORM,0,0), -1, -1, -1, -1); tick();

        for (int rs1 = 0; rs1 < 8; rs1++) begin
            for (int rs2 = 0; rs2 < 8; rs2++) begin
                for (int rd = 0; rd < 8; rd++) begin
                    int idx;
                    logic u1, u2, hit0, hit1;
                    idx  = rs1 * 64 + rs2 * 8 + rd;
                    u1   = (idx % 3) != 1;
                    u2   = (idx % 3) != 2;
                    hit0 = (u1 && rs1 == rd) || (u2 && rs2 == rd);
                    hit1 = hit0 && (rd != 0);
                    idle(); set_lu(3'(rd), 3'(rs1), 3'(rs2), u1, u2);
                    push2("sweep", c(hit0 ? LU : NORM,0,0), c(hit1 ? LU : NORM,0,0),
                          -1, -1, -1, -1);
                    tick();
                end
            end
        end
        idle();
        stim_done = 1'b1;
    end

    task automatic check(exp_t e);
        logic [9:0] act;
        int         s, f;
        if (e.dut == 0) begin
            act = {pc_en[0], ifid_en[0], idex_en[0], exmem_en[0], memwb_en[0],
                   ifid_flush[0], idex_flush[0], fault[0], state0};
            s = int'(stall0); f = int'(flush0);
        end else begin
            act = {pc_en[1], ifid_en[1], idex_en[1], exmem_en[1], memwb_en[1],
                   ifid_flush[1], idex_flush[1], fault[1], state1};
            s = int'(stall1); f = int'(flush1);
        end
        checks++;
        if (act !== e.ctl) begin
            errors++;
            $display("FAIL %s dut%0d ctl act=%b exp=%b", e.tag, e.dut, act, e.ctl);
        end
        if (e.stall >= 0) begin
            checks++;
            if (s != e.stall) begin
                errors++;
                $display("FAIL %s dut%0d stall_cnt act=%0d exp=%0d", e.tag, e.dut, s, e.stall);
            end
        end
        if (e.flush >= 0) begin
            checks++;
            if (f != e.flush) begin
                errors++;
                $display("FAIL %s dut%0d flush_cnt act=%0d exp=%0d", e.tag, e.dut, f, e.flush);
            end
        end
    endtask

    initial begin
        int cyc = 0;
        while (!(stim_done && sb.size() == 0)) begin
            @(negedge clk);
            cyc++;
            while (sb.size() > 0) begin
                check(sb.pop_front());
            end
            if (cyc > 5000) begin
                errors++;
                $display("FAIL timeout cycles=%0d pending=%0d", cyc, sb.size());
                break;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
